alu_seq: RTL and testbench

Parametrised, registered successor to the single-cycle CPU ALU. It decodes the 16-bit instruction word and captures operands on a start strobe. Single-cycle operations complete in one cycle; an optional iterative multiplier takes WIDTH cycles. It returns a registered result, NZCV flags and a destination-register write enable through a start/busy/done handshake. It sits between the register file read ports and the write-back stage of the multi-cycle CPU datapath.

---
 rtl/alu_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a start/busy/done handshake.
// Decodes a 16-bit instruction word, captures operands when a request is
// accepted and returns a registered result, NZCV flags, destination-register
// write enable and the destination address.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> iterative shift-add multiplier (opcode 1111, WIDTH cycles)
//   undefined -> no multiplier; busy is tied low and opcode 1111 is illegal
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0. done (and rd_wen for legal opcodes) is high for exactly one cycle
// per accepted request. aluout/flags/rd_addr only change on the edge that
// raises done. A start seen while busy=1 is dropped, not queued.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      instruction,
    input  logic [WIDTH-1:0] rsdata,
    input  logic [WIDTH-1:0] rmdata,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] aluout,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             rd_wen,
    output logic [2:0]       rd_addr
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_AND = 4'b1010;
    localparam logic [3:0] OP_OR  = 4'b1011;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_SHL = 4'b1101;
    localparam logic [3:0] OP_SHR = 4'b1110;
    localparam logic [3:0] OP_MUL = 4'b1111;

    // Instruction fields and operand selection
    logic [3:0]       op;
    logic             imm_type;
    logic [2:0]       rd;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [SW-1:0]    sh;
    logic             accept;
    logic             is_mul_op;
    logic             sc_fire;

    assign op       = instruction[15:12];
    assign imm_type = instruction[11];
    assign rd       = instruction[10:8];
    assign opa      = rsdata;
    assign opb      = imm_type ? N : rmdata;
    assign sh       = opb[SW-1:0];
    assign accept   = start && !busy;
    assign sc_fire  = accept && !is_mul_op;

    // Multiplier completion interface (constant when the multiplier is absent)
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic             mul_c;
    logic [2:0]       mul_rd;

    // Single-cycle datapath
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic             sc_legal;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH:0]   add_ext;

    // Combinational single-cycle ALU: result, carry, overflow and legality
    always_comb begin
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_legal = 1'b1;
        // The extra bit of each shift holds the last bit shifted out; it is
        // naturally zero when the shift amount is zero.
        shl_ext  = {1'b0, opa} << sh;
        shr_ext  = {opa, 1'b0} >> sh;
        add_ext  = {1'b0, opa} + {1'b0, opb};
        case (op)
            OP_ADD: begin
                sc_res = add_ext[WIDTH-1:0];
                sc_c   = add_ext[WIDTH];
                sc_v   = (opa[WIDTH-1] == opb[WIDTH-1]) &&
                         (sc_res[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = opa - opb;
                sc_c   = (opa >= opb);
                sc_v   = (opa[WIDTH-1] != opb[WIDTH-1]) &&
                         (sc_res[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND: sc_res = opa & opb;
            OP_OR:  sc_res = opa | opb;
            OP_XOR: sc_res = opa ^ opb;
            OP_SHL: begin
                sc_res = shl_ext[WIDTH-1:0];
                sc_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                sc_res = shr_ext[WIDTH:1];
                sc_c   = shr_ext[0];
            end
            default: sc_legal = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2:0]         rd_q;
    logic [2*WIDTH-1:0] mul_sum;

    assign is_mul_op = (op == OP_MUL);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: enter MUL on a multiply accept, leave after the last step
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_mul_op) state_d = S_MUL;
            S_MUL:   if (cnt_q == CW'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy for the whole multiply, completion on the final step
    always_comb begin
        busy     = (state_q == S_MUL);
        mul_done = (state_q == S_MUL) && (cnt_q == CW'(1));
    end

    // The final step's partial sum is the complete product, so the result is
    // taken from the adder output on the same edge that retires the multiply.
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_res = mul_sum[WIDTH-1:0];
    assign mul_c   = |mul_sum[2*WIDTH-1:WIDTH];
    assign mul_rd  = rd_q;

    // Shift-add multiplier: load on accept, one partial product per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rd_q     <= '0;
        end else if (accept && is_mul_op) begin
            cnt_q    <= CW'(WIDTH);
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, opa};
            mplier_q <= opb;
            rd_q     <= rd;
        end else if (state_q == S_MUL) begin
            cnt_q    <= cnt_q - CW'(1);
            acc_q    <= mul_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

`else

    assign is_mul_op = 1'b0;
    assign busy      = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
    assign mul_c     = 1'b0;
    assign mul_rd    = '0;

`endif

    // Result/flag/write-enable registers; done and rd_wen are single-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            aluout  <= '0;
            flags   <= 4'b0000;
            done    <= 1'b0;
            rd_wen  <= 1'b0;
            rd_addr <= 3'd0;
        end else begin
            done   <= 1'b0;
            rd_wen <= 1'b0;
            if (mul_done) begin
                aluout  <= mul_res;
                flags   <= {mul_res[WIDTH-1], (mul_res == '0), mul_c, 1'b0};
                done    <= 1'b1;
                rd_wen  <= 1'b1;
                rd_addr <= mul_rd;
            end else if (sc_fire) begin
                done    <= 1'b1;
                rd_addr <= rd;
                // Illegal opcodes complete but leave the architectural result alone
                if (sc_legal) begin
                    aluout <= sc_res;
                    flags  <= {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
                    rd_wen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=16).
// Multiplier scenarios are enabled when ALU_MUL_EN is defined.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  instruction;
    logic [W-1:0] rsdata;
    logic [W-1:0] rmdata;
    logic [W-1:0] n_imm;
    logic [W-1:0] aluout;
    logic [3:0]   flags;
    logic         busy;
    logic         done;
    logic         rd_wen;
    logic [2:0]   rd_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural result the model believes is currently held
    logic [W-1:0] model_out   = '0;
    logic [3:0]   model_flags = 4'b0000;
    logic [W-1:0] exp_q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .rsdata(rsdata), .rmdata(rmdata), .N(n_imm),
        .aluout(aluout), .flags(flags), .busy(busy), .done(done),
        .rd_wen(rd_wen), .rd_addr(rd_addr)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model from arithmetic definitions
    function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic legal,
                                    output logic [W-1:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, full, s, smax, smin;
        int sh;
        logic c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        smax = (64'sd1 <<< (W - 1)) - 1;
        smin = -(64'sd1 <<< (W - 1));
        sh = int'(b) % W;
        c = 1'b0; v = 1'b0; legal = 1'b1; full = 0; s = 0;
        case (op)
            4'b1000: begin full = ua + ub; c = (full >>> W) != 0; s = sa + sb; v = (s > smax) || (s < smin); end
            4'b1001: begin full = ua - ub; c = (ua >= ub); s = sa - sb; v = (s > smax) || (s < smin); end
            4'b1010: full = ua & ub;
            4'b1011: full = ua | ub;
            4'b1100: full = ua ^ ub;
            4'b1101: begin full = ua << sh; c = (sh != 0) && (((ua >> (W - sh)) & 1) != 0); end
            4'b1110: begin full = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
`ifdef ALU_MUL_EN
            4'b1111: begin full = ua * ub; c = (full >> W) != 0; end
`endif
            default: legal = 1'b0;
        endcase
        r = full[W-1:0];
        f = {r[W-1], (r == '0), c, v};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {W{1'b1}};
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Driver: present a request for one rising edge, return 1 time unit after it
    task automatic send(input logic [3:0] op, input logic typ, input logic [2:0] rd,
                        input logic [W-1:0] a, input logic [W-1:0] rm, input logic [W-1:0] imm);
        @(negedge clk);
        instruction = {op, typ, rd, 8'($urandom)};
        rsdata = a; rmdata = rm; n_imm = imm; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        instruction = 16'($urandom); rsdata = W'($urandom);
        rmdata = W'($urandom); n_imm = W'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; instruction = '0;
        rsdata = '0; rmdata = '0; n_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({aluout, flags, busy, done, rd_wen, rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got aluout=%h flags=%b busy=%b done=%b wen=%b rd=%0d required all zero",
                     aluout, flags, busy, done, rd_wen, rd_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        model_out = '0; model_flags = 4'b0000;
    endtask

    typedef struct {
        logic [3:0]   op;
        logic         typ;
        logic [2:0]   rd;
        logic [W-1:0] a, rm, imm, res;
        logic [3:0]   f;
        logic         wen;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[10];
        tbl[0] = '{4'b1000, 1'b0, 3'd3, 16'h7FFF, 16'h0001, 16'h5555, 16'h8000, 4'b1001, 1'b1};
        tbl[1] = '{4'b1000, 1'b1, 3'd5, 16'hFFFF, 16'h1234, 16'h0001, 16'h0000, 4'b0110, 1'b1};
        tbl[2] = '{4'b1001, 1'b0, 3'd1, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 4'b1000, 1'b1};
        tbl[3] = '{4'b1101, 1'b0, 3'd2, 16'h8001, 16'h0001, 16'h0000, 16'h0002, 4'b0010, 1'b1};
        tbl[4] = '{4'b0000, 1'b0, 3'd7, 16'h1111, 16'h2222, 16'h0000, 16'h0002, 4'b0010, 1'b0};
        tbl[5] = '{4'b1110, 1'b1, 3'd4, 16'h8002, 16'hFFFF, 16'h0011, 16'h4001, 4'b0000, 1'b1};
        tbl[6] = '{4'b0111, 1'b0, 3'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h4001, 4'b0000, 1'b0};
        tbl[7] = '{4'b1101, 1'b0, 3'd6, 16'h1234, 16'h0010, 16'h0000, 16'h1234, 4'b0000, 1'b1};
        tbl[8] = '{4'b1001, 1'b0, 3'd3, 16'h8000, 16'h0001, 16'h0000, 16'h7FFF, 4'b0011, 1'b1};
        tbl[9] = '{4'b1010, 1'b1, 3'd5, 16'hF0F0, 16'h0000, 16'h0FF0, 16'h00F0, 4'b0000, 1'b1};
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].op, tbl[i].typ, tbl[i].rd, tbl[i].a, tbl[i].rm, tbl[i].imm);
            n_checks++;
            if ({done, rd_wen, aluout, flags} !== {1'b1, tbl[i].wen, tbl[i].res, tbl[i].f}) begin
                n_fail++;
                $display("FAIL directed[%0d]: got done=%b wen=%b aluout=%h flags=%b required done=1 wen=%b aluout=%h flags=%b",
                         i, done, rd_wen, aluout, flags, tbl[i].wen, tbl[i].res, tbl[i].f);
            end
            if (tbl[i].wen) begin
                n_checks++;
                if (rd_addr !== tbl[i].rd) begin
                    n_fail++;
                    $display("FAIL directed_rd[%0d]: got %0d required %0d", i, rd_addr, tbl[i].rd);
                end
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({done, rd_wen} !== 2'b00) begin
                n_fail++;
                $display("FAIL directed_pulse[%0d]: got done=%b wen=%b required 0 0", i, done, rd_wen);
            end
        end
        model_out = 16'h00F0; model_flags = 4'b0000;
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic         typ, legal;
        logic [2:0]   rd;
        logic [W-1:0] a, rm, imm, r, e;
        logic [3:0]   f;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
`ifdef ALU_MUL_EN
            if (op == 4'b1111) op = 4'b1000;
`endif
            typ = 1'($urandom); rd = 3'($urandom);
            a = pick_operand(); rm = pick_operand(); imm = pick_operand();
            ref_alu(op, a, typ ? imm : rm, legal, r, f);
            if (legal) begin
                model_out = r; model_flags = f;
            end
            exp_q.push_back(model_out);
            send(op, typ, rd, a, rm, imm);
            e = exp_q.pop_front();
            n_checks++;
            if ({done, rd_wen, aluout, flags} !== {1'b1, legal, e, model_flags}) begin
                n_fail++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: got done=%b wen=%b aluout=%h flags=%b required done=1 wen=%b aluout=%h flags=%b",
                         i, op, a, typ ? imm : rm, done, rd_wen, aluout, flags, legal, e, model_flags);
            end
            if (legal) begin
                n_checks++;
                if (rd_addr !== rd) begin
                    n_fail++;
                    $display("FAIL random_rd[%0d]: got %0d required %0d", i, rd_addr, rd);
                end
            end
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        logic [W-1:0] a, b, r;
        logic [3:0]   f;
        logic         legal;
        int           cyc;
        bit           busy_ok;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 16'h0100 : pick_operand();
            b = (i == 0) ? 16'h0101 : pick_operand();
            ref_alu(4'b1111, a, b, legal, r, f);
            send(4'b1111, 1'b0, 3'd6, a, b, 16'h0000);
            n_checks++;
            if ({busy, done} !== 2'b10) begin
                n_fail++;
                $display("FAIL mul_accept[%0d]: got busy=%b done=%b required 1 0", i, busy, done);
            end
            cyc = 0; busy_ok = 1'b1;
            while (!done && cyc < W + 8) begin
                if (!busy) busy_ok = 1'b0;
                // A request raised mid-multiply must be dropped
                if (cyc == 3) begin
                    instruction = {4'b1000, 1'b0, 3'd1, 8'h00}; rsdata = 16'h0001; rmdata = 16'h0001; start = 1'b1;
                end
                if (cyc == 4) start = 1'b0;
                @(posedge clk);
                #1;
                cyc++;
            end
            start = 1'b0;
            n_checks++;
            if (cyc !== W || !busy_ok || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_latency[%0d]: got %0d cycles busy_held=%b busy_at_done=%b required %0d 1 0",
                         i, cyc, busy_ok, busy, W);
            end
            n_checks++;
            if ({rd_wen, aluout, flags, rd_addr} !== {1'b1, r, f, 3'd6}) begin
                n_fail++;
                $display("FAIL mul_result[%0d] %h*%h: got wen=%b aluout=%h flags=%b rd=%0d required 1 %h %b 6",
                         i, a, b, rd_wen, aluout, flags, rd_addr, r, f);
            end
            model_out = r; model_flags = f;
        end
        // Back-to-back: request issued during the done cycle completes one cycle later
        send(4'b1000, 1'b0, 3'd2, 16'h0100, 16'h0001, 16'h0000);
        n_checks++;
        if ({done, rd_wen, aluout, flags, rd_addr} !== {1'b1, 1'b1, 16'h0101, 4'b0000, 3'd2}) begin
            n_fail++;
            $display("FAIL back_to_back: got done=%b wen=%b aluout=%h flags=%b rd=%0d required 1 1 0101 0000 2",
                     done, rd_wen, aluout, flags, rd_addr);
        end
        model_out = 16'h0101; model_flags = 4'b0000;
        cyc = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) cyc++;
        end
        n_checks++;
        if (cyc != 0) begin
            n_fail++;
            $display("FAIL ignored_start: got %0d cycles of done/busy activity required 0", cyc);
        end
    endtask

    task automatic test_reset_mid_mul();
        int cyc;
        send(4'b1111, 1'b0, 3'd4, 16'h1234, 16'h0003, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if ({busy, done, rd_wen, aluout, flags} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got busy=%b done=%b wen=%b aluout=%h flags=%b required all zero",
                     busy, done, rd_wen, aluout, flags);
        end
        model_out = '0; model_flags = 4'b0000;
        cyc = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) cyc++;
        end
        n_checks++;
        if (cyc != 0) begin
            n_fail++;
            $display("FAIL reset_abort: got %0d cycles of done/busy activity required 0", cyc);
        end
        send(4'b1000, 1'b0, 3'd7, 16'h0002, 16'h0003, 16'h0000);
        n_checks++;
        if ({done, rd_wen, aluout, flags, rd_addr} !== {1'b1, 1'b1, 16'h0005, 4'b0000, 3'd7}) begin
            n_fail++;
            $display("FAIL add_after_reset: got done=%b wen=%b aluout=%h flags=%b rd=%0d required 1 1 0005 0000 7",
                     done, rd_wen, aluout, flags, rd_addr);
        end
    endtask
`else
    task automatic test_mul_disabled();
        send(4'b1111, 1'b0, 3'd6, 16'h0100, 16'h0101, 16'h0000);
        n_checks++;
        if ({done, rd_wen, busy, aluout, flags} !== {1'b1, 1'b0, 1'b0, model_out, model_flags}) begin
            n_fail++;
            $display("FAIL mul_disabled: got done=%b wen=%b busy=%b aluout=%h flags=%b required 1 0 0 %h %b",
                     done, rd_wen, busy, aluout, flags, model_out, model_flags);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL mul_disabled_pulse: got done=%b busy=%b required 0 0", done, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
`ifdef ALU_MUL_EN
        test_mul();
        test_reset_mid_mul();
`else
        test_mul_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
